// File: rtl/eth_pll_reconfig_pkg.sv
// Shared constants, FSM states and C-counter word builder for the Ethernet PLL retune logic.
package eth_pll_reconfig_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_IDX_W = 5;

  // altera_pll_reconfig register map
  localparam logic [ADDR_W-1:0] REG_MODE   = 6'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS = 6'd1;
  localparam logic [ADDR_W-1:0] REG_START  = 6'd2;
  localparam logic [ADDR_W-1:0] REG_C_CNT  = 6'd5;

  // MAC speed encoding
  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;
  localparam logic [1:0] SPEED_ILL   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_CNT,
    ST_WR_START,
    ST_RD_STATUS,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } state_e;

  // C-counter register payload
  typedef struct packed {
    logic [8:0]           rsvd;
    logic [CNT_IDX_W-1:0] idx;
    logic                 odd;
    logic                 bypass;
    logic [7:0]           hi;
    logic [7:0]           lo;
  } c_cnt_t;

  // C-counter word for a 375 MHz VCO: /3 -> 125 MHz, /15 -> 25 MHz, /150 -> 2.5 MHz
  function automatic logic [DATA_W-1:0] c_cnt_word(input logic [1:0] speed,
                                                   input logic [CNT_IDX_W-1:0] idx);
    c_cnt_t w;
    w.rsvd   = 9'd0;
    w.idx    = idx;
    w.bypass = 1'b0;
    case (speed)
      SPEED_1000M: begin w.hi = 8'd2;  w.lo = 8'd1;  w.odd = 1'b1; end
      SPEED_100M:  begin w.hi = 8'd8;  w.lo = 8'd7;  w.odd = 1'b1; end
      default:     begin w.hi = 8'd75; w.lo = 8'd75; w.odd = 1'b0; end
    endcase
    return DATA_W'(w);
  endfunction

endpackage

// File: rtl/eth_pll_mm_xact.sv
// Single-transaction Avalon-MM engine: latches one command, holds it across waitrequest.
module eth_pll_mm_xact
  import eth_pll_reconfig_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_rd,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              xact_done_c,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic              mgmt_read,
  output logic              mgmt_write,
  output logic [DATA_W-1:0] mgmt_writedata,
  input  logic [DATA_W-1:0] mgmt_readdata,
  input  logic              mgmt_waitrequest
);

  // Transfer completes in the cycle the strobe meets a low waitrequest; read data is zero-latency
  assign xact_done_c = (mgmt_read | mgmt_write) & ~mgmt_waitrequest;
  assign rd_data_c   = mgmt_readdata;

  // Launch a command when idle, drop the strobe on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mgmt_read      <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else if (xact_done_c) begin
      mgmt_read  <= 1'b0;
      mgmt_write <= 1'b0;
    end else if (!(mgmt_read || mgmt_write) && (cmd_rd || cmd_wr)) begin
      mgmt_read      <= cmd_rd;
      mgmt_write     <= cmd_wr & ~cmd_rd;
      mgmt_address   <= cmd_addr;
      mgmt_writedata <= cmd_data;
    end
  end

endmodule

// File: rtl/eth_pll_speed_reconfig.sv
// Retunes the Ethernet PLL C counters through altera_pll_reconfig on a MAC speed change.
module eth_pll_speed_reconfig
  import eth_pll_reconfig_pkg::*;
#(
  parameter int unsigned N_CNT        = 6,
  parameter int unsigned POLL_LIMIT   = 1023,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        speed_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        cur_speed,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic              mgmt_read,
  output logic              mgmt_write,
  output logic [DATA_W-1:0] mgmt_writedata,
  input  logic [DATA_W-1:0] mgmt_readdata,
  input  logic              mgmt_waitrequest,
  input  logic              pll_locked
);

  localparam int unsigned IDX_W  = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [1:0]          speed_q, speed_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [LOCK_W-1:0]   cyc_q, cyc_d;
  logic                busy_d, done_d, error_d;
  logic [1:0]          cur_speed_d;
  logic [1:0]          lock_sync;
  logic                bus_st_c;
  logic                cmd_rd_c, cmd_wr_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
  logic [DATA_W-1:0]   cmd_data_c;
  logic                xact_done_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                unused_rd_bits;

  // Only the status done bit matters
  assign unused_rd_bits = ^rd_data_c[DATA_W-1:1];

  eth_pll_mm_xact u_xact (
    .clk              (clk),
    .rst              (rst),
    .cmd_rd           (cmd_rd_c),
    .cmd_wr           (cmd_wr_c),
    .cmd_addr         (cmd_addr_c),
    .cmd_data         (cmd_data_c),
    .xact_done_c      (xact_done_c),
    .rd_data_c        (rd_data_c),
    .mgmt_address     (mgmt_address),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest)
  );

  // Two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_sync <= 2'b00;
    else     lock_sync <= {lock_sync[0], pll_locked};
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      speed_q   <= SPEED_1000M;
      k_q       <= '0;
      poll_q    <= '0;
      stab_q    <= '0;
      cyc_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cur_speed <= SPEED_1000M;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      speed_q   <= speed_d;
      k_q       <= k_d;
      poll_q    <= poll_d;
      stab_q    <= stab_d;
      cyc_q     <= cyc_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      cur_speed <= cur_speed_d;
    end
  end

  // Next state, bus commands and output updates
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    speed_d     = speed_q;
    k_d         = k_q;
    poll_d      = poll_q;
    stab_d      = stab_q;
    cyc_d       = cyc_q;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = error;
    cur_speed_d = cur_speed;
    bus_st_c    = 1'b0;
    cmd_rd_c    = 1'b0;
    cmd_wr_c    = 1'b0;
    cmd_addr_c  = '0;
    cmd_data_c  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          error_d   = 1'b0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          k_d       = '0;
          poll_d    = '0;
          if (speed_req == SPEED_ILL) begin
            state_d = ST_ERR;
          end else begin
            speed_d = speed_req;
            state_d = ST_WR_MODE;
          end
        end
      end
      ST_WR_MODE: begin
        bus_st_c   = 1'b1;
        cmd_addr_c = REG_MODE;
        cmd_data_c = DATA_W'(1);
        if (xact_done_c) state_d = ST_WR_CNT;
      end
      ST_WR_CNT: begin
        bus_st_c   = 1'b1;
        cmd_addr_c = REG_C_CNT;
        cmd_data_c = c_cnt_word(speed_q, CNT_IDX_W'(k_q));
        if (xact_done_c) begin
          if (k_q == IDX_W'(N_CNT - 1)) state_d = ST_WR_START;
          else                          k_d     = k_q + IDX_W'(1);
        end
      end
      ST_WR_START: begin
        bus_st_c   = 1'b1;
        cmd_addr_c = REG_START;
        cmd_data_c = DATA_W'(1);
        if (xact_done_c) state_d = ST_RD_STATUS;
      end
      ST_RD_STATUS: begin
        bus_st_c   = 1'b1;
        cmd_addr_c = REG_STATUS;
        if (xact_done_c) begin
          if (rd_data_c[0]) begin
            state_d = ST_WAIT_LOCK;
            stab_d  = '0;
            cyc_d   = '0;
          end else if (poll_q >= POLL_W'(POLL_LIMIT - 1)) begin
            state_d = ST_ERR;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync[1]) begin
          if (stab_q != STAB_W'(LOCK_STABLE)) stab_d = stab_q + STAB_W'(1);
        end else begin
          stab_d = '0;
        end
        if (cyc_q != LOCK_W'(LOCK_TIMEOUT)) cyc_d = cyc_q + LOCK_W'(1);
        if (lock_sync[1] && (stab_q >= STAB_W'(LOCK_STABLE - 1))) state_d = ST_DONE;
        else if (cyc_q >= LOCK_W'(LOCK_TIMEOUT - 1))             state_d = ST_ERR;
      end
      ST_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cur_speed_d = speed_q;
        state_d     = ST_IDLE;
      end
      ST_ERR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // One command per bus state; wait for its completion before the next
    if (bus_st_c && !pending_q) begin
      cmd_rd_c  = (state_q == ST_RD_STATUS);
      cmd_wr_c  = ~cmd_rd_c;
      pending_d = 1'b1;
    end
    if (xact_done_c) pending_d = 1'b0;
  end

endmodule

// File: tb/tb_eth_pll_speed_reconfig.sv
// Directed bench for eth_pll_speed_reconfig with an Avalon-MM slave model and lock stimulus.
module tb_eth_pll_speed_reconfig;
  import eth_pll_reconfig_pkg::*;

  localparam int unsigned N_CNT        = 6;
  localparam int unsigned POLL_LIMIT   = 1023;
  localparam int unsigned LOCK_TIMEOUT = 65535;
  localparam int unsigned LOCK_STABLE  = 16;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [1:0]  speed_req;
  logic        busy, done, error;
  logic [1:0]  cur_speed;
  logic [5:0]  mgmt_address;
  logic        mgmt_read, mgmt_write;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic        mgmt_waitrequest, pll_locked;

  eth_pll_speed_reconfig #(
    .N_CNT(N_CNT), .POLL_LIMIT(POLL_LIMIT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .speed_req(speed_req),
    .busy(busy), .done(done), .error(error), .cur_speed(cur_speed),
    .mgmt_address(mgmt_address), .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and monitor state
  int          max_stall = 0, status_on = 0, rd_cnt = 0, stall_left = 0;
  int          strobe_cycles = 0, stab_err = 0, both_err = 0, done_cnt = 0;
  int          rd_cyc = 0, done_cyc = 0, err_cyc = 0;
  bit          in_x = 0, hang_c = 0, err_prev = 0, toggle_en = 0, lock_level = 1;
  logic [5:0]  cap_a;
  logic [31:0] cap_d;
  logic        cap_w;
  logic [5:0]  wr_a[$];
  logic [31:0] wr_d[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] wlog(input int i);
    if (i < wr_a.size()) return {wr_a[i], wr_d[i]};
    return '1;
  endfunction

  // Avalon-MM slave: random stalls, status register, transfer log, done/error monitor
  initial begin
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (error && !err_prev) err_cyc = cyc;
      err_prev = error;
      if (rst) begin
        mgmt_waitrequest = 1'b0;
        in_x = 0;
      end else if (mgmt_read || mgmt_write) begin
        strobe_cycles++;
        if (mgmt_read && mgmt_write) both_err++;
        if (!in_x) begin
          in_x = 1;
          cap_a = mgmt_address; cap_d = mgmt_writedata; cap_w = mgmt_write;
          stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        end else if (cap_a !== mgmt_address || cap_d !== mgmt_writedata || cap_w !== mgmt_write) begin
          stab_err++;
        end
        if (hang_c && mgmt_address == 6'd5) stall_left = 1;
        if (stall_left > 0) begin
          mgmt_waitrequest = 1'b1;
          stall_left--;
        end else begin
          mgmt_waitrequest = 1'b0;
          in_x = 0;
          if (mgmt_write) begin
            wr_a.push_back(mgmt_address);
            wr_d.push_back(mgmt_writedata);
          end else begin
            rd_cnt++;
            rd_cyc = cyc;
            mgmt_readdata = (status_on != 0 && rd_cnt >= status_on) ? 32'h1 : 32'hFFFF_FFFE;
          end
        end
      end else begin
        mgmt_waitrequest = 1'b0;
        in_x = 0;
      end
    end
  end

  // pll_locked driver: steady level or toggling every 8 cycles
  initial begin
    int n;
    n = 0;
    pll_locked = 1'b1;
    forever begin
      @(negedge clk);
      if (toggle_en) begin
        n++;
        if (n == 8) begin pll_locked = ~pll_locked; n = 0; end
      end else begin
        pll_locked = lock_level;
        n = 0;
      end
    end
  end

  task automatic do_req(input logic [1:0] sp);
    @(negedge clk);
    req = 1'b1; speed_req = sp;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) check_eq({tag, "_timeout"}, 32'(n), 32'(-1));
    #1;
  endtask

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); rd_cnt = 0;
  endtask

  logic [37:0] exp_1g [8];
  int d0, s0;

  initial begin
    exp_1g = '{{6'd0, 32'h1}, {6'd5, 32'h0002_0201}, {6'd5, 32'h0006_0201}, {6'd5, 32'h000A_0201},
               {6'd5, 32'h000E_0201}, {6'd5, 32'h0012_0201}, {6'd5, 32'h0016_0201}, {6'd2, 32'h1}};
    rst = 1'b1; req = 1'b0; speed_req = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({busy, done, error, cur_speed, mgmt_read, mgmt_write}), 32'b0001000);
    check_eq("rst_addr", 32'(mgmt_address), 32'h0);
    check_eq("rst_wdata", mgmt_writedata, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1000M, no stalls, status set on 3rd read
    clear_log(); status_on = 3; max_stall = 0;
    do_req(SPEED_1000M);
    check_eq("g_busy", 32'(busy), 32'h1);
    wait_end("g", 500);
    check_eq("g_nwr", 32'(wr_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("g_wr%0d_addr", i), 32'(wlog(i) >> 32), 32'(exp_1g[i] >> 32));
      check_eq($sformatf("g_wr%0d_data", i), wlog(i)[31:0], exp_1g[i][31:0]);
    end
    check_eq("g_nrd", 32'(rd_cnt), 32'd3);
    check_eq("g_done_lat", 32'(done_cyc - rd_cyc), 32'(LOCK_STABLE + 2));
    check_eq("g_state", 32'({done, busy, error, cur_speed}), 32'b10010);
    @(negedge clk);
    check_eq("g_done_pulse", 32'(done), 32'h0);

    // 10M with random stalls
    clear_log(); status_on = 2; max_stall = 5; stab_err = 0; both_err = 0;
    do_req(SPEED_10M);
    wait_end("m10", 1000);
    check_eq("m10_c0", wlog(1)[31:0], 32'h0000_4B4B);
    check_eq("m10_c5", wlog(6)[31:0], 32'h0014_4B4B);
    check_eq("m10_stable", 32'(stab_err), 32'd0);
    check_eq("m10_onestrobe", 32'(both_err), 32'd0);
    check_eq("m10_speed", 32'({done, error, cur_speed}), 32'b10_00);
    max_stall = 0;
    repeat (2) @(negedge clk);

    // Illegal speed
    s0 = strobe_cycles;
    do_req(SPEED_ILL);
    check_eq("ill_busy1", 32'({busy, error}), 32'b10);
    @(negedge clk);
    check_eq("ill_busy0_err", 32'({busy, error}), 32'b01);
    repeat (3) @(negedge clk);
    check_eq("ill_nobus", 32'(strobe_cycles - s0), 32'd0);
    check_eq("ill_speed", 32'(cur_speed), 32'(SPEED_10M));

    // Status never set: exactly POLL_LIMIT reads then error
    clear_log(); status_on = 0; d0 = done_cnt;
    do_req(SPEED_1000M);
    check_eq("poll_err_clr", 32'(error), 32'h0);
    wait_end("poll", 5000);
    repeat (3) @(negedge clk);
    check_eq("poll_nrd", 32'(rd_cnt), 32'(POLL_LIMIT));
    check_eq("poll_err", 32'({error, busy}), 32'b10);
    check_eq("poll_nodone", 32'(done_cnt - d0), 32'd0);
    clear_log(); status_on = 1;
    do_req(SPEED_10M);
    check_eq("poll_req_clr", 32'(error), 32'h0);
    wait_end("poll_re", 500);
    check_eq("poll_re_ok", 32'({done, error, cur_speed}), 32'b10_00);

    // Lock toggling -> timeout; a req while busy is ignored
    clear_log(); status_on = 1; toggle_en = 1; d0 = done_cnt;
    do_req(SPEED_100M);
    for (int n = 0; n < 200 && wr_a.size() < 3; n++) @(negedge clk);
    do_req(SPEED_10M);
    wait_end("lk", LOCK_TIMEOUT + 2000);
    check_eq("lk_lat", 32'(err_cyc - rd_cyc), 32'(LOCK_TIMEOUT + 2));
    check_eq("lk_nwr", 32'(wr_a.size()), 32'd8);
    check_eq("lk_c0", wlog(1)[31:0], 32'h0002_0807);
    check_eq("lk_c5", wlog(6)[31:0], 32'h0016_0807);
    check_eq("lk_err", 32'({error, busy, cur_speed}), 32'b10_00);
    check_eq("lk_nodone", 32'(done_cnt - d0), 32'd0);
    toggle_en = 0; lock_level = 1;

    // Reset during a stalled C-counter write
    clear_log(); hang_c = 1;
    do_req(SPEED_10M);
    for (int n = 0; n < 100 && !(mgmt_write && mgmt_address == 6'd5 && mgmt_waitrequest); n++)
      @(negedge clk);
    check_eq("rs_stalled", 32'({mgmt_write, mgmt_address}), 32'b1_000101);
    #2 rst = 1'b1;
    #1;
    check_eq("rs_strobe", 32'({mgmt_read, mgmt_write}), 32'b00);
    check_eq("rs_ctrl", 32'({busy, done, error, cur_speed}), 32'b00010);
    check_eq("rs_bus", 32'({mgmt_address, mgmt_writedata}), 32'h0);
    hang_c = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_log(); status_on = 1;
    do_req(SPEED_100M);
    wait_end("rs_re", 500);
    check_eq("rs_wr0", 32'(wlog(0) >> 32), 32'h0);
    check_eq("rs_wr0_data", wlog(0)[31:0], 32'h1);
    check_eq("rs_wr1_data", wlog(1)[31:0], 32'h0002_0807);
    check_eq("rs_nwr", 32'(wr_a.size()), 32'd8);
    check_eq("rs_speed", 32'({done, cur_speed}), 32'b1_01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_pll_speed_reconfig.md
Name: eth_pll_speed_reconfig

Overview:
- Avalon-MM master that retunes the Ethernet PLL output dividers when the MAC link speed changes.
- Sits between the MAC speed-detect logic and the altera_pll_reconfig core attached to the Ethernet PLL's reconfig_to_pll/reconfig_from_pll buses.
- Programs C counters 0..N_CNT-1, starts reconfiguration, polls for completion and waits for PLL lock.
- Targets: VCO 375 MHz; outputs 125 / 25 / 2.5 MHz for 1000 / 100 / 10 Mb/s.

Parameters:
- N_CNT, 6: number of C counters reprogrammed (counters 0..N_CNT-1); legal range 1..18.
- POLL_LIMIT, 1023: maximum status reads before declaring a reconfig timeout.
- LOCK_TIMEOUT, 65535: maximum cycles to wait for pll_locked after reconfig completes.
- LOCK_STABLE, 16: consecutive cycles pll_locked must stay high to count as locked.

Ports:
- clk  in  1  management clock; all logic is single-clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle request pulse; samples speed_req.
- speed_req  in  2  requested speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = illegal.
- busy  out  1  high from request acceptance until done or error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag; cleared on the next accepted req.
- cur_speed  out  2  last successfully programmed speed.
- mgmt_address  out  6  Avalon-MM address.
- mgmt_read  out  1  Avalon-MM read strobe.
- mgmt_write  out  1  Avalon-MM write strobe.
- mgmt_writedata  out  32  Avalon-MM write data.
- mgmt_readdata  in  32  Avalon-MM read data.
- mgmt_waitrequest  in  1  Avalon-MM wait request.
- pll_locked  in  1  PLL locked; asynchronous, synchronised internally with 2 flops.

Behaviour:
- Reset values: busy 0, done 0, error 0, cur_speed 10, mgmt_read 0, mgmt_write 0, mgmt_address 0, mgmt_writedata 0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately: strobes drop, no further bus cycles.
- Bus protocol: at most one strobe active at a time. Address, data and strobe are held stable while mgmt_waitrequest = 1. A transfer completes in the cycle where the strobe is high and mgmt_waitrequest = 0. mgmt_readdata is sampled in that same cycle (zero read latency).
- Request acceptance: req is honoured only in IDLE. req while busy is ignored.
- FSM states and transitions:
  - IDLE: on req, clear error and set busy. If speed_req = 11, go to ERR with no bus activity; otherwise latch speed into a register.
  - WR_MODE: write address 0, data 0x1 (polling mode).
  - WR_CNT: write address 5 for k = 0..N_CNT-1, in ascending k order.
    - Data layout: [22:18] = k, [17] = odd, [16] = bypass (0), [15:8] = hi, [7:0] = lo.
    - 1000M: hi 2, lo 1, odd 1.
    - 100M: hi 8, lo 7, odd 1.
    - 10M: hi 75, lo 75, odd 0.
  - WR_START: write address 2, data 0x1.
  - RD_STATUS: read address 1.
    - readdata[0] = 1: go to WAIT_LOCK.
    - Otherwise re-read; back-to-back reads are allowed.
    - Completed reads counted; POLL_LIMIT reads without the bit set: go to ERR.
  - WAIT_LOCK: cycle counter starts at 0 on entry, together with a stability counter.
    - Stability counter increments while synced pll_locked = 1 and resets to 0 when it is 0.
    - On reaching LOCK_STABLE: go to DONE.
    - Cycle counter reaching LOCK_TIMEOUT first: go to ERR.
  - DONE: done = 1 for one cycle, cur_speed updated to the latched speed, busy cleared, return to IDLE.
  - ERR: error set, busy cleared, cur_speed unchanged, return to IDLE.
- Counter widths: every counter saturates at its limit and never wraps. Widths are derived from the parameters with $clog2.
- Phase registers are never written, so each counter's existing phase setting is preserved.

Decomposition:
- Package eth_pll_reconfig_pkg:
  - Register address constants: MODE = 0, STATUS = 1, START = 2, C_CNT = 5.
  - Speed encoding constants.
  - FSM state enum.
  - Function that returns the C-counter data word from speed and counter index.
- Sub-module eth_pll_mm_xact: single-transaction Avalon-MM engine. Takes a one-cycle command (rd/wr, addr, data), holds it across waitrequest, and returns a done pulse plus the read data. The FSM issues one command and waits for that done pulse.

Test Plan:
- Program 1000M, waitrequest held 0:
  - Writes in order: (0, 0x1), (5, 0x00020201), (5, 0x00060201), (5, 0x000A0201), (5, 0x000E0201), (5, 0x00120201), (5, 0x00160201), (2, 0x1).
  - Then reads of address 1; status bit set on the 3rd read; pll_locked high.
  - Expect done pulse LOCK_STABLE + 2 cycles after the 3rd read, and cur_speed = 10.
- Program 10M with waitrequest randomly asserted 0–5 cycles per transfer:
  - Every mgmt_writedata/address stays stable while stalled.
  - C0 write = 0x00004B4B, C5 write = 0x00144B4B.
  - Final cur_speed = 00.
- speed_req = 11: error = 1 on the next cycle; busy high for that 1 cycle only; no mgmt_read/mgmt_write ever asserted; cur_speed unchanged.
- Status bit never set: exactly POLL_LIMIT reads, then error = 1, no done; a subsequent valid req clears error.
- pll_locked toggling every 8 cycles with LOCK_STABLE = 16: error after LOCK_TIMEOUT cycles in WAIT_LOCK. Separately, a req pulse during busy is ignored and causes no extra writes.
- rst asserted during WR_CNT while mgmt_waitrequest = 1: strobes drop asynchronously and all outputs return to reset values. A fresh req after reset restarts from WR_MODE.
